// File: rtl/chanlink_pkg.sv
// Shared definitions for the channel-link write scheduler: FSM encoding, overlap-tag
// field layout and tag helpers.
package chanlink_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_XFER  = 3'd2;
  localparam state_t S_STALL = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  localparam int TAG_W        = 7;
  localparam int TAG_EVT_END  = 6;
  localparam int TAG_MOVLP    = 5;
  localparam int TAG_OVRLP    = 4;
  localparam int TAG_OCNT_MSB = 3;
  localparam int TAG_OCNT_LSB = 0;

  localparam logic [3:0] OCNT_SAT = 4'd15;

  function automatic logic [3:0] sat_ocnt(input logic [7:0] occ);
    if (occ > 8'(OCNT_SAT)) begin
      return OCNT_SAT;
    end else begin
      return occ[3:0];
    end
  endfunction

  function automatic logic [TAG_W-1:0] pack_tag(input logic evt_end, input logic movlp,
                                                input logic ovrlp, input logic [3:0] ocnt);
    logic [TAG_W-1:0] t;
    t = {TAG_W{1'b0}};
    t[TAG_EVT_END] = evt_end;
    t[TAG_MOVLP] = movlp;
    t[TAG_OVRLP] = ovrlp;
    t[TAG_OCNT_MSB:TAG_OCNT_LSB] = ocnt;
    return t;
  endfunction

endpackage

// File: rtl/chanlink_dly_pipe.sv
// Fixed-depth shift register with asynchronous clear; lines write strobes up with
// ring-buffer read data.
module chanlink_dly_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Next-stage values: shift by one.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Pipe registers; clear kills any in-flight strobe immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {W{1'b0}};
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/chanlink_wr_sched.sv
// Write-side sequencer for the channel-link event FIFO pair.
// Optional dropped-request counter: define CHANLINK_SCHED_DROP_CNT_EN.
module chanlink_wr_sched
  import chanlink_pkg::*;
#(
  parameter int NCHAN      = 6,
  parameter int ADDR_W     = 8,
  parameter int PEND_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic              WCLK,
  input  logic              RST_RESYNC,
  input  logic              L1A_MATCH,
  input  logic [ADDR_W-1:0] RING_PTR,
  input  logic [6:0]        SAMP_MAX,
  input  logic              EVT_AFL,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [2:0]        CHAN_SEL,
  output logic              WREN,
  output logic [6:0]        OVRLP_EVT_DATA,
  output logic              L1A_WRT_EN,
  output logic              WARN,
  output logic              BUSY,
  output logic [7:0]        DROP_CNT
);

  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0]    CHAN_LAST = 3'(NCHAN - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(PEND_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        chan_q, chan_d;
  logic [6:0]        smp_q, smp_d;
  logic [6:0]        smax_q, smax_d;
  logic              ovl_q, ovl_d;

  logic [ADDR_W-1:0]     qptr_q [PEND_DEPTH];
  logic [ADDR_W-1:0]     qptr_d [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] qovl_q, qovl_d;
  logic [PW-1:0]         wr_idx_q, wr_idx_d;
  logic [PW-1:0]         rd_idx_q, rd_idx_d;
  logic [CW-1:0]         count_q, count_d;

  logic             full_s, pop_s, push_s, last_s, strobe_s;
  logic [TAG_W-1:0] tag_s;
  logic [TAG_W:0]   pipe_in_s, pipe_out_s;

  // Pending-request queue: a pop in LOAD frees a slot for a same-cycle push.
  always_comb begin
    full_s   = (count_q == CNT_FULL);
    pop_s    = (state_q == S_LOAD);
    push_s   = L1A_MATCH && (!full_s || pop_s);
    qptr_d   = qptr_q;
    qovl_d   = qovl_q;
    if (push_s) begin
      qptr_d[wr_idx_q] = RING_PTR;
      qovl_d[wr_idx_q] = (state_q != S_IDLE) || (count_q != {CW{1'b0}});
      wr_idx_d = wr_idx_q + PW'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (pop_s) begin
      rd_idx_d = rd_idx_q + PW'(1);
    end else begin
      rd_idx_d = rd_idx_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // Event sequencing; stalls are taken only after a sample's last channel.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    chan_d    = chan_q;
    smp_d     = smp_q;
    smax_d    = smax_q;
    ovl_d     = ovl_q;
    last_s    = (smp_q == smax_q) && (chan_q == CHAN_LAST);
    strobe_s  = (state_q == S_XFER);
    case (state_q)
      S_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rd_addr_d = qptr_q[rd_idx_q];
        ovl_d     = qovl_q[rd_idx_q];
        smax_d    = SAMP_MAX;
        smp_d     = 7'd0;
        chan_d    = 3'd0;
        state_d   = S_XFER;
      end
      S_XFER: begin
        if (last_s) begin
          state_d = S_DONE;
        end else if (chan_q == CHAN_LAST) begin
          chan_d    = 3'd0;
          smp_d     = smp_q + 7'd1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (EVT_AFL) begin
            state_d = S_STALL;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          chan_d = chan_q + 3'd1;
        end
      end
      S_STALL: begin
        if (!EVT_AFL) begin
          state_d = S_XFER;
        end else begin
          state_d = S_STALL;
        end
      end
      S_DONE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scheduler and queue registers.
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      state_q   <= S_IDLE;
      rd_addr_q <= {ADDR_W{1'b0}};
      chan_q    <= 3'd0;
      smp_q     <= 7'd0;
      smax_q    <= 7'd0;
      ovl_q     <= 1'b0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        qptr_q[i] <= {ADDR_W{1'b0}};
      end
      qovl_q    <= {PEND_DEPTH{1'b0}};
      wr_idx_q  <= {PW{1'b0}};
      rd_idx_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      chan_q    <= chan_d;
      smp_q     <= smp_d;
      smax_q    <= smax_d;
      ovl_q     <= ovl_d;
      qptr_q    <= qptr_d;
      qovl_q    <= qovl_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
    end
  end

  // Tag uses the live occupancy, so later requests show up on the current event's words.
  assign tag_s     = pack_tag(last_s, count_q >= CW'(2), ovl_q, sat_ocnt(8'(count_q)));
  assign pipe_in_s = strobe_s ? {1'b1, tag_s} : {(TAG_W + 1){1'b0}};

  chanlink_dly_pipe #(
    .W     (TAG_W + 1),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk  (WCLK),
    .arst (RST_RESYNC),
    .din  (pipe_in_s),
    .dout (pipe_out_s)
  );

  assign RD_ADDR        = rd_addr_q;
  assign CHAN_SEL       = chan_q;
  assign WREN           = pipe_out_s[TAG_W];
  assign OVRLP_EVT_DATA = pipe_out_s[TAG_W-1:0];
  assign L1A_WRT_EN     = (state_q == S_LOAD);
  assign WARN           = (state_q == S_STALL) || full_s;
  assign BUSY           = (state_q != S_IDLE) || (count_q != {CW{1'b0}});

`ifdef CHANLINK_SCHED_DROP_CNT_EN
  logic       drop_s;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of requests refused by a full queue.
  always_comb begin
    drop_s = L1A_MATCH && !push_s;
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`else
  assign DROP_CNT = 8'h00;
`endif

endmodule
